// File: rtl/serial_addsub_word.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first,
// with valid/ready handshakes on operands and result.
module serial_addsub_word #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [DIGIT-1:0] digit_out,
  output logic             digit_valid,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = WIDTH + DIGIT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [DIGIT-1:0] dig_q, dig_d;
  logic             dv_q, dv_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;

  logic             st_idle, st_run, st_done;
  logic             accept;
  logic [DIGIT:0]   sum;
  logic [XW-1:0]    a_ext, b_ext, r_ext;
  logic [WIDTH-1:0] res_nx;

  assign st_idle = (state_q == S_IDLE);
  assign st_run  = (state_q == S_RUN);
  assign st_done = (state_q == S_DONE);

  assign in_ready = !rst && (st_idle || (st_done && out_ready));
  assign accept   = in_valid && in_ready;

  // One digit of the ripple; the carry is registered between digits.
  assign sum = {1'b0, a_sh_q[DIGIT-1:0]}
             + {1'b0, b_sh_q[DIGIT-1:0]}
             + (DIGIT+1)'(carry_q);

  assign a_ext  = {{DIGIT{1'b0}}, a_sh_q};
  assign b_ext  = {{DIGIT{1'b0}}, b_sh_q};
  assign r_ext  = {sum[DIGIT-1:0], res_q};
  assign res_nx = r_ext[XW-1:DIGIT];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    dv_d    = 1'b0;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b ^ {WIDTH{sub}};
      carry_d = sub;
      cnt_d   = '0;
      amsb_d  = a[WIDTH-1];
      bmsb_d  = b[WIDTH-1] ^ sub;
      state_d = S_RUN;
    end else begin
      unique case (1'b1)
        st_run: begin
          carry_d = sum[DIGIT];
          res_d   = res_nx;
          a_sh_d  = a_ext[XW-1:DIGIT];
          b_sh_d  = b_ext[XW-1:DIGIT];
          dig_d   = sum[DIGIT-1:0];
          dv_d    = 1'b1;
          if (cnt_q == LAST) begin
            cout_d  = sum[DIGIT];
            ovf_d   = (amsb_q == bmsb_q)
                   && (res_nx[WIDTH-1] != amsb_q);
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        st_done: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
      dv_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
      dv_q    <= dv_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
    end
  end

  assign out_valid   = st_done;
  assign busy        = st_run;
  assign result      = res_q;
  assign carry_out   = cout_q;
  assign overflow    = ovf_q;
  assign digit_out   = dig_q;
  assign digit_valid = dv_q;

endmodule

// File: tb/tb_serial_addsub_word.sv
// Bench for serial_addsub_word: four instances (DIGIT 1,2,4,8)
// checked every cycle against a transaction-level model.
module tb_serial_addsub_word;

  logic       clk = 1'b0;
  logic       rst[4];
  logic       in_valid[4];
  logic       in_ready[4];
  logic [7:0] a[4];
  logic [7:0] b[4];
  logic       sub[4];
  logic       out_valid[4];
  logic       out_ready[4];
  logic [7:0] res[4];
  logic       co[4];
  logic       ov[4];
  logic [7:0] dout[4];
  logic       dv[4];
  logic       busy[4];

  int vecs = 0;
  int errs = 0;
  int dq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gd
    logic [(1<<g)-1:0] d;
    serial_addsub_word #(.WIDTH(8), .DIGIT(1 << g)) u (
      .clk(clk),
      .rst(rst[g]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .a(a[g]),
      .b(b[g]),
      .sub(sub[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .result(res[g]),
      .carry_out(co[g]),
      .overflow(ov[g]),
      .digit_out(d),
      .digit_valid(dv[g]),
      .busy(busy[g])
    );
    assign dout[g] = 8'(d);
  end

  function automatic int nd(int k);
    return 8 >> k;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, exp);
    end
  endtask

  // Reference arithmetic: {ov, co, res[7:0]}
  function automatic logic [9:0] ref_op(logic [7:0] x, logic [7:0] y, logic s);
    int sx, sy, ux, uy, u, ideal;
    logic [7:0] r;
    logic c, o;
    sx = $signed(x);
    sy = $signed(y);
    ux = int'(x);
    uy = int'(y);
    u = s ? ux - uy : ux + uy;
    ideal = s ? sx - sy : sx + sy;
    r = u[7:0];
    c = s ? (ux >= uy) : (u > 255);
    o = (ideal > 127) || (ideal < -128);
    return {o, c, r};
  endfunction

  // Model: phase 0 idle, 1 computing, 2 result held
  int   m_ph[4];
  int   m_j[4];
  int   m_lastj[4];
  int   m_res[4];
  logic m_co[4];
  logic m_ov[4];
  logic m_dv[4];
  logic m_live[4];

  initial for (int k = 0; k < 4; k++) m_live[k] = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      logic acc;
      logic [9:0] e;
      int dexp;
      if (m_live[k]) begin
        chk("busy", k, 32'(busy[k]), 32'(m_ph[k] == 1));
        chk("out_valid", k, 32'(out_valid[k]), 32'(m_ph[k] == 2));
        chk("in_ready", k, 32'(in_ready[k]),
            32'(!rst[k] && (m_ph[k] == 0 || (m_ph[k] == 2 && out_ready[k]))));
        chk("digit_valid", k, 32'(dv[k]), 32'(m_dv[k]));
        if (m_ph[k] == 2) begin
          chk("result", k, 32'(res[k]), 32'(m_res[k]));
          chk("carry_out", k, 32'(co[k]), 32'(m_co[k]));
          chk("overflow", k, 32'(ov[k]), 32'(m_ov[k]));
        end
        if (m_dv[k]) begin
          dexp = (m_res[k] >> (m_lastj[k] * (1 << k))) & ((1 << (1 << k)) - 1);
          chk("digit_out", k, 32'(dout[k]), dexp);
        end
      end
      if (rst[k]) begin
        m_live[k] = 1'b1;
        m_ph[k] = 0;
        m_dv[k] = 1'b0;
      end else if (m_live[k]) begin
        m_dv[k] = (m_ph[k] == 1);
        acc = in_valid[k] && (m_ph[k] == 0 || (m_ph[k] == 2 && out_ready[k]));
        if (m_ph[k] == 1) begin
          m_lastj[k] = m_j[k];
          m_j[k]++;
          if (m_j[k] == nd(k)) m_ph[k] = 2;
        end else if (acc) begin
          e = ref_op(a[k], b[k], sub[k]);
          m_res[k] = int'(e[7:0]);
          m_co[k] = e[8];
          m_ov[k] = e[9];
          m_j[k] = 0;
          m_ph[k] = 1;
        end else if (m_ph[k] == 2 && out_ready[k]) begin
          m_ph[k] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int k, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input int stall, input bit noise,
                        output logic [7:0] r, output logic c, output logic o,
                        output int lat);
    int t;
    t = 0;
    while (!in_ready[k] && t < 20) begin
      tick();
      t++;
    end
    chk("in_ready_wait", k, 32'(in_ready[k]), 32'd1);
    in_valid[k] = 1'b1;
    a[k] = x;
    b[k] = y;
    sub[k] = s;
    tick();
    in_valid[k] = 1'b0;
    if (k == 0) dq.delete();
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      if (noise) begin
        in_valid[k] = 1'($urandom_range(0, 1));
        a[k] = 8'($urandom);
        b[k] = 8'($urandom);
        sub[k] = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
      if (k == 0 && dv[k]) dq.push_back(int'(dout[k]));
    end
    in_valid[k] = 1'b0;
    chk("out_valid_wait", k, 32'(out_valid[k]), 32'd1);
    repeat (stall) tick();
    r = res[k];
    c = co[k];
    o = ov[k];
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  task automatic rand_run(input int k, input int cnt);
    logic [7:0] x, y, r;
    logic s, c, o;
    logic [9:0] e;
    int lat;
    for (int i = 0; i < cnt; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      run_op(k, x, y, s, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             r, c, o, lat);
      e = ref_op(x, y, s);
      chk("rand_result", k, 32'(r), 32'(e[7:0]));
      chk("rand_latency", k, lat, nd(k));
    end
  endtask

  logic [7:0] r;
  logic c, o;
  int lat;
  int exp_dig[8] = '{1, 0, 1, 1, 0, 0, 0, 1};

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      a[k] = '0;
      b[k] = '0;
      sub[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("rst_out_valid", k, 32'(out_valid[k]), 0);
      chk("rst_in_ready", k, 32'(in_ready[k]), 0);
      chk("rst_result", k, 32'(res[k]), 0);
      chk("rst_busy", k, 32'(busy[k]), 0);
      chk("rst_digit_valid", k, 32'(dv[k]), 0);
      chk("rst_flags", k, {30'd0, co[k], ov[k]}, 0);
      rst[k] = 1'b0;
    end
    tick();

    run_op(0, 8'h5A, 8'h33, 1'b0, 0, 1'b0, r, c, o, lat);
    chk("t1_result", 0, 32'(r), 32'h8D);
    chk("t1_carry", 0, 32'(c), 0);
    chk("t1_ovf", 0, 32'(o), 1);
    chk("t1_latency", 0, lat, 8);
    chk("t1_ndigits", 0, dq.size(), 8);
    for (int i = 0; i < 8 && i < dq.size(); i++)
      chk("t1_digit", 0, dq[i], exp_dig[i]);

    run_op(0, 8'hFF, 8'h01, 1'b0, 2, 1'b0, r, c, o, lat);
    chk("t2_result", 0, 32'(r), 32'h00);
    chk("t2_carry", 0, 32'(c), 1);
    chk("t2_ovf", 0, 32'(o), 0);
    run_op(0, 8'h80, 8'h01, 1'b1, 0, 1'b0, r, c, o, lat);
    chk("t3_result", 0, 32'(r), 32'h7F);
    chk("t3_carry", 0, 32'(c), 1);
    chk("t3_ovf", 0, 32'(o), 1);
    run_op(0, 8'h10, 8'h20, 1'b1, 1, 1'b0, r, c, o, lat);
    chk("t4_result", 0, 32'(r), 32'hF0);
    chk("t4_carry", 0, 32'(c), 0);
    chk("t4_ovf", 0, 32'(o), 0);

    // Backpressure and same-edge handoff on the DIGIT=4 instance
    in_valid[2] = 1'b1;
    a[2] = 8'h12;
    b[2] = 8'h34;
    sub[2] = 1'b0;
    tick();
    in_valid[2] = 1'b0;
    tick();
    chk("bp_early", 2, 32'(out_valid[2]), 0);
    tick();
    chk("bp_valid", 2, 32'(out_valid[2]), 1);
    chk("bp_result", 2, 32'(res[2]), 32'h46);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 2, 32'(out_valid[2]), 1);
      chk("bp_hold_result", 2, 32'(res[2]), 32'h46);
      chk("bp_hold_in_ready", 2, 32'(in_ready[2]), 0);
    end
    out_ready[2] = 1'b1;
    in_valid[2] = 1'b1;
    a[2] = 8'h01;
    b[2] = 8'h01;
    #1;
    chk("b2b_in_ready", 2, 32'(in_ready[2]), 1);
    tick();
    in_valid[2] = 1'b0;
    out_ready[2] = 1'b0;
    chk("b2b_valid_low", 2, 32'(out_valid[2]), 0);
    chk("b2b_busy", 2, 32'(busy[2]), 1);
    tick();
    tick();
    chk("b2b_valid", 2, 32'(out_valid[2]), 1);
    chk("b2b_result", 2, 32'(res[2]), 32'h02);
    out_ready[2] = 1'b1;
    tick();
    out_ready[2] = 1'b0;

    // Reset on the third RUN edge
    in_valid[0] = 1'b1;
    a[0] = 8'hAA;
    b[0] = 8'h55;
    sub[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    rst[0] = 1'b1;
    tick();
    chk("mr_out_valid", 0, 32'(out_valid[0]), 0);
    chk("mr_result", 0, 32'(res[0]), 0);
    chk("mr_digit_valid", 0, 32'(dv[0]), 0);
    chk("mr_busy", 0, 32'(busy[0]), 0);
    rst[0] = 1'b0;
    tick();
    run_op(0, 8'h01, 8'h02, 1'b0, 0, 1'b0, r, c, o, lat);
    chk("mr_fresh_result", 0, 32'(r), 32'h03);
    chk("mr_fresh_carry", 0, 32'(c), 0);

    fork
      rand_run(0, 250);
      rand_run(1, 250);
      rand_run(2, 250);
      rand_run(3, 250);
    join

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/serial_addsub_word.md
Name: serial_addsub_word

Overview:
- Parametrised digit-serial adder/subtractor. It accepts two WIDTH-bit operands plus an add/sub mode through a valid/ready handshake.
- It processes DIGIT bits per cycle, LSB first, with a registered carry chain between digits.
- It returns the full WIDTH-bit result, carry-out and signed overflow through a second valid/ready handshake.
- It replaces the fixed 1-bit, two-state serial adder in arithmetic datapaths where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH. N = WIDTH/DIGIT is the number of RUN cycles per operation.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand set is valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B; 1: A−B, computed as A+~B+1.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- carry_out  output  1  carry out of the MSB; for sub, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.
- digit_out  output  DIGIT  most recently computed digit, for serial observation.
- digit_valid  output  1  digit_out was produced on the previous edge.
- busy  output  1  state is RUN.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at an edge):
  - state=IDLE; cnt, carry register, operand shift registers, result, carry_out, overflow, digit_out, digit_valid, out_valid all 0.
  - Reset aborts any operation in progress. No partial result is ever presented.
  - in_ready=0 while rst=1.
- in_ready is combinational: (state==IDLE) || (state==DONE && out_ready), gated by !rst.
- out_valid is registered and equals (state==DONE).
- Accept (in_valid && in_ready at an edge):
  - Load a into the A shift register.
  - Load b^{WIDTH{sub}} into the B shift register.
  - Set the carry register to sub and cnt to 0.
  - Latch a[WIDTH-1] and (b[WIDTH-1]^sub) for the overflow check.
  - Go to RUN.
  - Operands are sampled only at accept; later changes on a/b/sub have no effect.
- RUN, each edge:
  - {c, d} = A_sh[DIGIT-1:0] + B_sh[DIGIT-1:0] + carry, a DIGIT+1-bit sum.
  - carry ← c.
  - Shift d into the result register from the MSB end.
  - A_sh and B_sh shift right by DIGIT.
  - digit_out ← d; digit_valid ← 1.
  - cnt ← cnt+1.
  - On the edge where cnt==N−1:
    - carry_out ← c.
    - overflow ← (latched a_msb == latched b_msb) && (new result MSB != a_msb).
    - Go to DONE.
- digit_valid is 0 in every cycle not immediately following a RUN edge.
- Latency: out_valid rises N cycles after the accept edge.
  - DIGIT=1, WIDTH=8: 8 cycles.
  - DIGIT=4, WIDTH=8: 2 cycles.
- DONE:
  - result, carry_out and overflow are held stable while out_ready=0.
  - On out_ready=1 with no new accept: go to IDLE; out_valid falls next cycle.
  - Simultaneous out_ready && in_valid in DONE: the result is consumed and the new operands are accepted on the same edge. Go directly to RUN; out_valid=0 next cycle.
  - Back-to-back throughput: one operation per N+1 cycles.
- in_valid while busy is ignored; the operands are not captured.
- The cnt width is ceil(log2(N)), minimum 1. cnt wraps only via reset or accept, never by overflow.
- The carry register never leaks between operations; it is reloaded to sub at each accept.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x5A, b=0x33, sub=0 → after 8 cycles result=0x8D, carry_out=0, overflow=1. digit_out sequence LSB-first is 1,0,1,1,0,0,0,1.
- WIDTH=8, DIGIT=1, wrap-around: a=0xFF, b=0x01, sub=0 → result=0x00, carry_out=1, overflow=0. Then a=0x80, b=0x01, sub=1 → result=0x7F, carry_out=1, overflow=1.
- WIDTH=8, DIGIT=1, subtract with borrow: a=0x10, b=0x20, sub=1 → result=0xF0, carry_out=0, overflow=0.
- Backpressure and back-to-back, WIDTH=8, DIGIT=4: a=0x12, b=0x34, add → out_valid after 2 cycles with result=0x46.
  - Hold out_ready=0 for 5 cycles: result, out_valid and in_ready=0 stay stable.
  - Then assert out_ready with in_valid, a=0x01, b=0x01 → handshake on the same edge, out_valid low next cycle, result=0x02 two cycles later.
- Reset mid-operation: accept a=0xAA, b=0x55; assert rst on the 3rd RUN edge → next cycle out_valid=0, result=0, digit_valid=0, busy=0.
  - After deasserting rst, a fresh a=0x01, b=0x02 gives 0x03 with carry_out=0, with no stale carry.
- Random: 1000 operations with random a/b/sub and random out_ready stalls, DIGIT∈{1,2,4,8}. Every handshaken result matches (a ± b) mod 256, carry_out and overflow match a reference model, and latency is exactly N.
